gate_vector_checker: RTL and testbench

Self-checking truth-table sequencer for 2-input combinational gate blocks, such as the NAND-built gate primitives. It drives the four input vectors onto a gate under test, waits a programmable settle time, samples the gate output, and compares each sample against an expected truth table. It is the response-checking end of the gate stimulus/response path and is synthesizable, so the same check runs in simulation benches and on-board self-test.

---
 rtl/gate_vector_checker.sv | 127 ++++++++++++
 tb/tb_gate_vector_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_checker.sv
// Truth-table sequencer for a 2-input gate: walks {a,b} = 00..11, holds each
// vector for SETTLE+1 cycles, samples dut_y and records mismatches.

module gate_vector_slot (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hit,
    output logic flag
);
    always_ff @(posedge clk) begin
        if (rst || clear)
            flag <= 1'b0;
        else if (hit)
            flag <= 1'b1;
    end
endmodule

module gate_vector_checker #(
    parameter logic [3:0]  EXPECTED = 4'b1110,
    parameter int unsigned SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       stim_a,
    output logic       stim_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);
    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] err_count_n;
    logic       done_n, pass_n;
    logic       clear, sample, mismatch;
    logic [3:0] hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        done_n      = 1'b0;
        pass_n      = pass;
        err_count_n = err_count;
        clear       = 1'b0;
        sample      = 1'b0;
        mismatch    = (dut_y != EXPECTED[idx]);
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = RUN;
                    idx_n       = 2'd0;
                    cnt_n       = SETTLE_W;
                    clear       = 1'b1;
                    pass_n      = 1'b0;
                    err_count_n = 3'd0;
                end
            end
            RUN: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    sample = 1'b1;
                    if (mismatch)
                        err_count_n = err_count + 3'd1;
                    if (idx != 2'd3) begin
                        idx_n = idx + 2'd1;
                        cnt_n = SETTLE_W;
                    end else begin
                        // pass must include the final vector's own outcome
                        state_n = IDLE;
                        idx_n   = 2'd0;
                        cnt_n   = 4'd0;
                        done_n  = 1'b1;
                        pass_n  = (err_count_n == 3'd0);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // One sticky mismatch flag per truth-table row.
    for (genvar k = 0; k < 4; k++) begin : g_slot
        assign hit[k] = sample && mismatch && (idx == 2'(k));
        gate_vector_slot u_slot (
            .clk  (clk),
            .rst  (rst),
            .clear(clear),
            .hit  (hit[k]),
            .flag (err_mask[k])
        );
    end

    assign stim_a  = idx[1];
    assign stim_b  = idx[0];
    assign vec_idx = idx;
    assign busy    = (state == RUN);
endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: four parameter variants share start/rst and
// a selectable gate model; a timer-based model is compared every cycle.

module tb_gate_vector_checker;
    localparam int N = 4;
    localparam int S_ARR [N] = '{2, 2, 0, 1};
    localparam logic [3:0] E_ARR [N] = '{4'b1110, 4'b1000, 4'b1110, 4'b1110};

    typedef enum int {G_OR, G_ZERO, G_AND, G_REGOR} gate_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    gate_t mode = G_OR;

    logic [N-1:0] y;
    logic [N-1:0] y_reg;
    wire  [N-1:0] sa, sb, busy, done, pass;
    wire  [1:0]   vidx [N];
    wire  [2:0]   ec   [N];
    wire  [3:0]   em   [N];

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    gate_vector_checker #(.EXPECTED(4'b1110), .SETTLE(2)) u_def (
        .clk(clk), .rst(rst), .start(start), .dut_y(y[0]), .stim_a(sa[0]), .stim_b(sb[0]),
        .vec_idx(vidx[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(ec[0]), .err_mask(em[0]));
    gate_vector_checker #(.EXPECTED(4'b1000), .SETTLE(2)) u_and (
        .clk(clk), .rst(rst), .start(start), .dut_y(y[1]), .stim_a(sa[1]), .stim_b(sb[1]),
        .vec_idx(vidx[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(ec[1]), .err_mask(em[1]));
    gate_vector_checker #(.EXPECTED(4'b1110), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .dut_y(y[2]), .stim_a(sa[2]), .stim_b(sb[2]),
        .vec_idx(vidx[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(ec[2]), .err_mask(em[2]));
    gate_vector_checker #(.EXPECTED(4'b1110), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .dut_y(y[3]), .stim_a(sa[3]), .stim_b(sb[3]),
        .vec_idx(vidx[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_count(ec[3]), .err_mask(em[3]));

    // Gates under test, one per checker instance.
    always_ff @(posedge clk) y_reg <= sa | sb;

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                G_OR:    y[i] = sa[i] | sb[i];
                G_ZERO:  y[i] = 1'b0;
                G_AND:   y[i] = sa[i] & sb[i];
                default: y[i] = y_reg[i];
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a run is a timer t counting edges since accept; vector = t/(S+1),
    // and the sample falls on the last edge of each (S+1)-cycle slot.
    logic       model_ok = 1'b0;
    logic       m_busy [N];
    logic       m_done [N];
    logic       m_pass [N];
    int         m_t    [N];
    logic [2:0] m_ec   [N];
    logic [3:0] m_em   [N];
    int         per_m, v_m;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            per_m = S_ARR[i] + 1;
            if (rst) begin
                model_ok  = 1'b1;
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
                m_t[i] = 0; m_ec[i] = 3'd0; m_em[i] = 4'd0;
            end else if (!m_busy[i]) begin
                m_done[i] = 1'b0;
                if (start) begin
                    m_busy[i] = 1'b1; m_t[i] = 0; m_pass[i] = 1'b0;
                    m_ec[i] = 3'd0; m_em[i] = 4'd0;
                end
            end else begin
                m_done[i] = 1'b0;
                v_m = m_t[i] / per_m;
                if (m_t[i] % per_m == per_m - 1) begin
                    if (y[i] != E_ARR[i][v_m]) begin
                        m_em[i][v_m] = 1'b1;
                        m_ec[i] = m_ec[i] + 3'd1;
                    end
                    if (v_m == 3) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_pass[i] = (m_ec[i] == 3'd0);
                    end
                end
                m_t[i]++;
            end
        end
    end

    // Per-cycle compare plus latency / stimulus monitors.
    logic [1:0]   cmp_v;
    logic [13:0]  cmp_e, cmp_a;
    logic [N-1:0] prev_busy = '0;
    int           acc [N];
    int           lat [N];
    int           done_cnt [N] = '{0, 0, 0, 0};
    logic [23:0]  seq = '0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (model_ok) begin
                cmp_v = m_busy[i] ? 2'(m_t[i] / (S_ARR[i] + 1)) : 2'd0;
                cmp_e = {cmp_v[1], cmp_v[0], cmp_v, m_busy[i], m_done[i], m_pass[i], m_ec[i], m_em[i]};
                cmp_a = {sa[i], sb[i], vidx[i], busy[i], done[i], pass[i], ec[i], em[i]};
                check($sformatf("cycle_u%0d", i), 32'(cmp_a), 32'(cmp_e));
            end
            if (busy[i] === 1'b1 && prev_busy[i] !== 1'b1) acc[i] = cyc;
            if (done[i] === 1'b1) begin
                lat[i] = cyc - acc[i];
                done_cnt[i]++;
            end
        end
        if (busy[0] === 1'b1) seq = {seq[21:0], sa[0], sb[0]};
        prev_busy = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input gate_t g);
        int d0;
        mode = g;
        tick();
        d0 = done_cnt[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && done_cnt[0] == d0; k++) tick();
        check("run_done_seen", 32'(done_cnt[0] - d0), 32'd1);
        tick();
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'({sa[0], sb[0], vidx[0], busy[0], done[0], pass[0], ec[0], em[0]}), 32'd0);
        rst = 1'b0;

        // OR gate, all variants with OR table should pass
        seq = '0;
        run(G_OR);
        check("or_latency", 32'(lat[0]), 32'd12);
        check("or_pass", 32'(pass[0]), 32'd1);
        check("or_err_count", 32'(ec[0]), 32'd0);
        check("or_err_mask", 32'(em[0]), 32'd0);
        check("or_stim_seq", 32'(seq), 32'(24'b000000_010101_101010_111111));
        check("or_s0_latency", 32'(lat[2]), 32'd4);

        // Stuck-at-0
        run(G_ZERO);
        check("zero_err_count", 32'(ec[0]), 32'd3);
        check("zero_err_mask", 32'(em[0]), 32'b1110);
        check("zero_pass", 32'(pass[0]), 32'd0);

        // AND gate against OR table and AND table
        run(G_AND);
        check("and_err_mask", 32'(em[0]), 32'b0110);
        check("and_err_count", 32'(ec[0]), 32'd2);
        check("and_pass", 32'(pass[0]), 32'd0);
        check("and_table_pass", 32'(pass[1]), 32'd1);

        // Registered OR gate
        run(G_REGOR);
        check("reg_s0_latency", 32'(lat[2]), 32'd4);
        check("reg_s0_err_mask", 32'(em[2]), 32'b0010);
        check("reg_s0_err_count", 32'(ec[2]), 32'd1);
        check("reg_s0_pass", 32'(pass[2]), 32'd0);
        check("reg_s1_pass", 32'(pass[3]), 32'd1);

        // start held high while busy is ignored
        mode = G_OR;
        tick();
        d0 = done_cnt[0];
        start = 1'b1;
        repeat (10) tick();
        start = 1'b0;
        repeat (20) tick();
        check("held_start_one_done", 32'(done_cnt[0] - d0), 32'd1);
        check("held_start_latency", 32'(lat[0]), 32'd12);

        // start in the done cycle begins a new run with results cleared
        mode = G_ZERO;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && done[0] !== 1'b1; k++) tick();
        check("b2b_first_done", 32'(done[0]), 32'd1);
        check("b2b_first_count", 32'(ec[0]), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy[0]), 32'd1);
        check("b2b_cleared", 32'({pass[0], ec[0], em[0]}), 32'd0);
        for (int k = 0; k < 40 && done[0] !== 1'b1; k++) tick();
        check("b2b_second_count", 32'(ec[0]), 32'd3);
        tick();

        // reset at cycle 5 of a run
        mode = G_OR;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrun_reset_outputs", 32'({sa[0], sb[0], vidx[0], busy[0], done[0], pass[0], ec[0], em[0]}), 32'd0);
        rst = 1'b0;
        d0 = done_cnt[0];
        repeat (20) tick();
        check("midrun_no_done", 32'(done_cnt[0] - d0), 32'd0);
        run(G_OR);
        check("after_reset_pass", 32'(pass[0]), 32'd1);
        check("after_reset_latency", 32'(lat[0]), 32'd12);

        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
